// File: rtl/regfile_wsel_decoder.sv
// -----------------------------------------------------------------------------
// regfile_wsel_decoder
//   Destination-register write-select decoder and scoreboard for KGP miniRISC.
//   Reserves a destination register when the issue stage hands over an rd.
//   On a writeback to a reserved register, it produces a registered one-hot
//   write enable for the register file and releases the reservation.
//   issue_ready is held low while rd is still in flight (WAW stall). It is
//   raised again in the same cycle as the writeback that frees that rd.
//
// Ports
//   clk          in   1         rising-edge clock
//   rst          in   1         synchronous active-high reset
//   issue_valid  in   1         issue stage presents issue_rd
//   issue_rd     in   ADDR_W    destination index to reserve
//   issue_ready  out  1         combinational: issue_rd may be reserved now
//   wb_valid     in   1         writeback of wb_rd this cycle
//   wb_rd        in   ADDR_W    index being written back
//   wr_en_onehot out  N_REGS    registered one-hot regfile write enable
//   busy         out  N_REGS    registered scoreboard bitmap
//   busy_cnt     out  ADDR_W+1  registered number of busy registers
//   wb_err       out  1         registered pulse: writeback to a non-busy reg
// -----------------------------------------------------------------------------
module regfile_wsel_decoder #(
    parameter int ADDR_W    = 5,
    parameter int N_REGS    = 32,
    parameter bit R0_LOCKED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic [N_REGS-1:0] wr_en_onehot,
    output logic [N_REGS-1:0] busy,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              wb_err
);

    // 5 -> 32 decode; the inverse of the regfile's priority encoder.
    function automatic logic [N_REGS-1:0] onehot_of(input logic [ADDR_W-1:0] idx);
        logic [N_REGS-1:0] v;
        v      = {N_REGS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [N_REGS-1:0] busy_q,     busy_d;
    logic [N_REGS-1:0] wr_en_q,    wr_en_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              wb_err_q,   wb_err_d;

    logic issue_r0_s;   // issue targets the hard-wired zero register
    logic wb_r0_s;      // writeback targets the hard-wired zero register
    logic wb_hit_s;
    logic wb_miss_s;
    logic same_rd_s;
    logic set_en_s;
    logic inc_s;
    logic dec_s;

    // Scoreboard next-state, write-enable decode and stall logic.
    always_comb begin
        issue_r0_s  = R0_LOCKED && (issue_rd == {ADDR_W{1'b0}});
        wb_r0_s     = R0_LOCKED && (wb_rd == {ADDR_W{1'b0}});
        wb_hit_s    = wb_valid & busy_q[wb_rd] & ~wb_r0_s;
        wb_miss_s   = wb_valid & ~busy_q[wb_rd] & ~wb_r0_s;
        same_rd_s   = (issue_rd == wb_rd);

        // A writeback retiring the same rd this cycle frees it for reissue.
        issue_ready = ~busy_q[issue_rd] | (wb_hit_s & same_rd_s);
        set_en_s    = issue_valid & issue_ready & ~issue_r0_s;

        // Clear first, then set, so a same-rd issue keeps the bit (set wins).
        busy_d = busy_q;
        if (wb_hit_s) begin
            busy_d = busy_d & ~onehot_of(wb_rd);
        end else begin
            busy_d = busy_d;
        end
        if (set_en_s) begin
            busy_d = busy_d | onehot_of(issue_rd);
        end else begin
            busy_d = busy_d;
        end

        // A bit is only counted when it really changes state. For a same-rd
        // issue+writeback the bit was already set and stays set, so neither
        // counter moves.
        inc_s      = set_en_s & ~busy_q[issue_rd];
        dec_s      = wb_hit_s & ~(set_en_s & same_rd_s);
        busy_cnt_d = busy_cnt_q + {{ADDR_W{1'b0}}, inc_s} - {{ADDR_W{1'b0}}, dec_s};

        if (wb_hit_s) begin
            wr_en_d = onehot_of(wb_rd);
        end else begin
            wr_en_d = {N_REGS{1'b0}};
        end
        wb_err_d = wb_miss_s;
    end

    // State and output registers; reset drops every reservation and pending enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= {N_REGS{1'b0}};
            busy_cnt_q <= {(ADDR_W+1){1'b0}};
            wr_en_q    <= {N_REGS{1'b0}};
            wb_err_q   <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            wr_en_q    <= wr_en_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign busy         = busy_q;
    assign busy_cnt     = busy_cnt_q;
    assign wr_en_onehot = wr_en_q;
    assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_regfile_wsel_decoder.sv
// -----------------------------------------------------------------------------
// Bench for regfile_wsel_decoder (ADDR_W=5, N_REGS=32, R0_LOCKED=1).
// Directed cycle table, hand-written fill/reset sequence, then random traffic
// against a rule-level scoreboard model.
// -----------------------------------------------------------------------------
module tb_regfile_wsel_decoder;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wr_en_onehot;
    logic [31:0] busy;
    logic [5:0]  busy_cnt;
    logic        wb_err;

    int errors = 0;
    int checks = 0;

    regfile_wsel_decoder #(.ADDR_W(5), .N_REGS(32), .R0_LOCKED(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wr_en_onehot (wr_en_onehot),
        .busy         (busy),
        .busy_cnt     (busy_cnt),
        .wb_err       (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic        wv;
        logic [4:0]  wrd;
        logic        exp_ready;
        logic [31:0] exp_wr;
        logic [31:0] exp_busy;
        logic [5:0]  exp_cnt;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [4:0] ird,
                                input logic wv, input logic [4:0] wrd,
                                input logic rdy, input logic [31:0] wr,
                                input logic [31:0] bz, input logic [5:0] cnt,
                                input logic err);
        vec_t v;
        v.iv = iv; v.ird = ird; v.wv = wv; v.wrd = wrd;
        v.exp_ready = rdy; v.exp_wr = wr; v.exp_busy = bz;
        v.exp_cnt = cnt; v.exp_err = err;
        return v;
    endfunction

    // Drive one cycle: check issue_ready before the edge, registered outputs after.
    task automatic cycle(input string tag, input logic r, input logic iv, input logic [4:0] ird,
                         input logic wv, input logic [4:0] wrd, input logic exp_ready,
                         input logic [31:0] exp_wr, input logic [31:0] exp_busy,
                         input logic [5:0] exp_cnt, input logic exp_err);
        rst = r; issue_valid = iv; issue_rd = ird; wb_valid = wv; wb_rd = wrd;
        #1;
        chk({tag, " ready"}, {31'd0, issue_ready}, {31'd0, exp_ready});
        @(posedge clk);
        #1;
        chk({tag, " wr_en"}, wr_en_onehot, exp_wr);
        chk({tag, " busy"},  busy, exp_busy);
        chk({tag, " cnt"},   {26'd0, busy_cnt}, {26'd0, exp_cnt});
        chk({tag, " wb_err"}, {31'd0, wb_err}, {31'd0, exp_err});
    endtask

    vec_t tbl[16];

    // Reference scoreboard state for the random phase.
    bit m_busy[32];

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_rd = 5'd0; wb_valid = 1'b0; wb_rd = 5'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset wr_en", wr_en_onehot, 32'h0);
        chk("reset busy",  busy, 32'h0);
        chk("reset cnt",   {26'd0, busy_cnt}, 32'd0);
        chk("reset wb_err", {31'd0, wb_err}, 32'd0);

        // ---------------- directed table ----------------
        tbl[0]  = mk(1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 32'h0,        32'h0000_0020, 6'd1, 1'b0);
        tbl[1]  = mk(1'b0, 5'd0,  1'b1, 5'd5,  1'b1, 32'h0000_0020, 32'h0,        6'd0, 1'b0);
        tbl[2]  = mk(1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 32'h0,        32'h0,        6'd0, 1'b0);
        tbl[3]  = mk(1'b1, 5'd7,  1'b0, 5'd0,  1'b1, 32'h0,        32'h0000_0080, 6'd1, 1'b0);
        tbl[4]  = mk(1'b1, 5'd7,  1'b0, 5'd0,  1'b0, 32'h0,        32'h0000_0080, 6'd1, 1'b0);
        tbl[5]  = mk(1'b1, 5'd7,  1'b1, 5'd7,  1'b1, 32'h0000_0080, 32'h0000_0080, 6'd1, 1'b0);
        tbl[6]  = mk(1'b0, 5'd0,  1'b1, 5'd7,  1'b1, 32'h0000_0080, 32'h0,        6'd0, 1'b0);
        tbl[7]  = mk(1'b0, 5'd9,  1'b1, 5'd9,  1'b1, 32'h0,        32'h0,        6'd0, 1'b1);
        tbl[8]  = mk(1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 32'h0,        32'h0,        6'd0, 1'b0);
        tbl[9]  = mk(1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 32'h0,        32'h0,        6'd0, 1'b0);
        tbl[10] = mk(1'b0, 5'd0,  1'b1, 5'd0,  1'b1, 32'h0,        32'h0,        6'd0, 1'b0);
        tbl[11] = mk(1'b1, 5'd3,  1'b0, 5'd0,  1'b1, 32'h0,        32'h0000_0008, 6'd1, 1'b0);
        tbl[12] = mk(1'b1, 5'd31, 1'b1, 5'd3,  1'b1, 32'h0000_0008, 32'h8000_0000, 6'd1, 1'b0);
        tbl[13] = mk(1'b0, 5'd0,  1'b1, 5'd31, 1'b1, 32'h8000_0000, 32'h0,        6'd0, 1'b0);
        tbl[14] = mk(1'b1, 5'd3,  1'b1, 5'd3,  1'b1, 32'h0,        32'h0000_0008, 6'd1, 1'b1);
        tbl[15] = mk(1'b0, 5'd0,  1'b1, 5'd3,  1'b1, 32'h0000_0008, 32'h0,        6'd0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            cycle($sformatf("vec%0d", i), 1'b0, tbl[i].iv, tbl[i].ird, tbl[i].wv, tbl[i].wrd,
                  tbl[i].exp_ready, tbl[i].exp_wr, tbl[i].exp_busy, tbl[i].exp_cnt, tbl[i].exp_err);
        end

        // ---------------- fill rd 1..31 back-to-back ----------------
        for (int r = 1; r < 32; r++) begin
            cycle($sformatf("fill%0d", r), 1'b0, 1'b1, 5'(r), 1'b0, 5'd0, 1'b1, 32'h0,
                  (32'hFFFF_FFFF >> (31 - r)) & 32'hFFFF_FFFE, 6'(r), 1'b0);
        end
        // Full scoreboard: WAW stall on rd 31.
        cycle("full stall", 1'b0, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFE, 6'd31, 1'b0);
        // Reset mid-stream with a pending hit: nothing survives, no enable issued.
        cycle("mid rst", 1'b1, 1'b1, 5'd31, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0, 6'd0, 1'b0);
        // The lost reservation now reports as an error.
        cycle("post rst wb", 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 32'h0, 32'h0, 6'd0, 1'b1);

        // ---------------- random traffic vs. rule model ----------------
        for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic        r, iv, wv, hit, rdy, err;
            logic [4:0]  ird, wrd;
            logic [31:0] exp_wr, exp_busy;
            int          cnt;
            r   = ($urandom_range(0, 99) == 0);
            iv  = $urandom_range(0, 1);
            wv  = $urandom_range(0, 1);
            ird = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wrd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));

            // Register 0 is never busy; a writeback retires only a busy register.
            hit = wv && m_busy[wrd] && (wrd != 5'd0);
            rdy = !m_busy[ird] || (hit && (wrd == ird));
            if (r) begin
                for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
                exp_wr = 32'h0;
                err    = 1'b0;
            end else begin
                exp_wr = hit ? (32'h1 << wrd) : 32'h0;
                err    = wv && !m_busy[wrd] && (wrd != 5'd0);
                if (hit) m_busy[wrd] = 1'b0;
                if (iv && rdy && (ird != 5'd0)) m_busy[ird] = 1'b1;
            end
            exp_busy = 32'h0;
            cnt      = 0;
            for (int k = 0; k < 32; k++) begin
                exp_busy[k] = m_busy[k];
                cnt += int'(m_busy[k]);
            end
            cycle($sformatf("rnd%0d", n), r, iv, ird, wv, wrd, rdy, exp_wr, exp_busy, 6'(cnt), err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
